edge_event_arbiter: RTL and testbench

//  Detects rising edges on N_CH independent level inputs, counts pending events per channel
//  and serialises them onto one shared event port with a valid/ready handshake.

---
 rtl/edge_arb_pkg.sv | 47 ++++
 rtl/edge_pend_ch.sv | 66 ++++++
 rtl/edge_event_arbiter.sv | 153 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// ============================================================================
// edge_arb_pkg
// Shared types and helpers for the edge event arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OFFER)
//   rr_next()   : round-robin search that returns the first requesting channel
//                 at or above a start pointer, wrapping at n-1 -> 0.
// Supports up to 16 channels. Requests and the pointer are passed zero-extended
// to the full 16-bit and 4-bit widths.
// ============================================================================
package edge_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int MAX_CH = 16;

    // Searches the channels ptr, ptr+1, ... (mod n) and returns the first one
    // whose request bit is set. The caller checks separately that at least one
    // request is set. If none is set, the function returns 0.
    function automatic logic [3:0] rr_next(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int                n
    );
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    found = 1'b1;
                    sel   = idx[3:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/edge_pend_ch.sv
// ============================================================================
// edge_pend_ch
// One channel of the edge event arbiter. It contains the rising-edge detector,
// a saturating pending-event counter and a sticky overflow flag.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   level      : level input (already synchronous to clk)
//   en         : channel enable. When 0, new edges are ignored.
//   dec        : an event of this channel transfers this cycle
//   ovf_clr    : clears the overflow flag
//   pending    : current pending count
//   ovf        : sticky flag. Set when an edge was lost to saturation.
// ============================================================================
module edge_pend_ch #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              level,
    input  logic              en,
    input  logic              dec,
    input  logic              ovf_clr,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    logic              level_q_reg;
    logic [PEND_W-1:0] pending_reg;
    logic              ovf_reg;
    logic              tick;
    logic              sat;
    logic              lost;

    assign tick = level & ~level_q_reg & en;
    assign sat  = &pending_reg;
    // A tick together with a drain does not lose an event. The count simply
    // stays the same, so only a tick without a drain at saturation is an overflow.
    assign lost = tick & sat & ~dec;

    // level_q starts at all ones. A level that is already high when reset
    // is released therefore does not count as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q_reg <= 1'b1;
            pending_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            level_q_reg <= level;
            if (tick && !dec && !sat) begin
                pending_reg <= pending_reg + PEND_W'(1);
            end else if (dec && !tick) begin
                pending_reg <= pending_reg - PEND_W'(1);
            end
            // A new overflow has priority over a clear in the same cycle.
            if (lost) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;
    assign ovf     = ovf_reg;

endmodule

// File: rtl/edge_event_arbiter.sv
// ============================================================================
// edge_event_arbiter
// Detects rising edges on N_CH level inputs and keeps a count of pending events
// per channel. It sends the events one at a time on a valid/ready event port.
// Channels are served in round-robin order. The channel that was just granted
// has the lowest priority for the next selection.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   level      : raw level inputs, one per channel
//   ch_en      : per-channel enable for new edges
//   evt_valid  : an event is offered on evt_ch
//   evt_ch     : channel index of the offered event
//   evt_ready  : consumer accepts. A transfer happens when evt_valid and evt_ready are both high.
//   ovf        : sticky per-channel overflow flags
//   ovf_clr    : clears all ovf bits
// Build option:
//   EDGE_ARB_SYNC_EN : adds a two-flop synchroniser on every level input.
//                      This adds two cycles of latency.
// ============================================================================
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int PEND_W = 2,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] level,
    input  logic [N_CH-1:0] ch_en,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    input  logic            evt_ready,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    arb_state_t        state_reg;
    logic              evt_valid_reg;
    logic [CH_W-1:0]   evt_ch_reg;
    logic [CH_W-1:0]   ptr_reg;

    logic [N_CH-1:0]   level_s;
    logic [N_CH-1:0]   dec;
    logic [N_CH-1:0]   req;
    logic [PEND_W-1:0] pending [N_CH];
    logic              transfer;
    logic              any_req;
    logic [CH_W-1:0]   after_grant;
    logic [CH_W-1:0]   search_ptr;
    logic [CH_W-1:0]   sel;
    logic [MAX_CH-1:0] req_full;
    logic [3:0]        ptr_full;
    logic [3:0]        sel_full;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= level;
            sync2_reg <= sync1_reg;
        end
    end

    assign level_s = sync2_reg;
`else
    assign level_s = level;
`endif

    assign transfer = evt_valid_reg & evt_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign dec[gi] = transfer && (evt_ch_reg == CH_W'(gi));

            edge_pend_ch #(
                .PEND_W (PEND_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .level   (level_s[gi]),
                .en      (ch_en[gi]),
                .dec     (dec[gi]),
                .ovf_clr (ovf_clr),
                .pending (pending[gi]),
                .ovf     (ovf[gi])
            );

            // The request uses the count after this cycle's decrement. New
            // ticks from this cycle are not included.
            assign req[gi] = (pending[gi] != '0) &&
                             !(dec[gi] && (pending[gi] == PEND_W'(1)));
        end
    endgenerate

    assign any_req     = |req;
    assign after_grant = (evt_ch_reg == CH_W'(N_CH - 1)) ? '0 : evt_ch_reg + CH_W'(1);
    // When a grant is made in the same cycle, the search starts just past the granted channel.
    assign search_ptr  = transfer ? after_grant : ptr_reg;

    always_comb begin
        req_full                = '0;
        req_full[N_CH-1:0]      = req;
        ptr_full                = '0;
        ptr_full[CH_W-1:0]      = search_ptr;
        sel_full                = rr_next(req_full, ptr_full, N_CH);
        sel                     = sel_full[CH_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            evt_valid_reg <= 1'b0;
            evt_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        evt_ch_reg    <= sel;
                        evt_valid_reg <= 1'b1;
                        state_reg     <= OFFER;
                    end
                end
                OFFER: begin
                    if (transfer) begin
                        ptr_reg <= after_grant;
                        if (any_req) begin
                            evt_ch_reg <= sel;
                        end else begin
                            evt_valid_reg <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    evt_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt_ch    = evt_ch_reg;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] level;
    logic [3:0] ch_en;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_ready;
    logic [3:0] ovf;
    logic       ovf_clr;

    int checks = 0;
    int passes = 0;
    int cnt2;
    int cnt_other;

    edge_event_arbiter #(.N_CH(4), .PEND_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .ch_en     (ch_en),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset     = 1'b1;
        level     = 4'b0000;
        ch_en     = 4'b1111;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        step();
        step();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ch", 32'(evt_ch), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        step();

        // 1: a single edge on ch0 gives one event, then the port goes idle.
        level[0] = 1'b1;
        step();
        check("t1_latency_low", 32'(evt_valid), 32'd0);
        step();
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_ch", 32'(evt_ch), 32'd0);
        step();
        check("t1_done", 32'(evt_valid), 32'd0);
        step();
        check("t1_no_repeat", 32'(evt_valid), 32'd0);
        level[0] = 1'b0;
        step();

        // 2: ch1 and ch3 rise in the same cycle. ch1 is served first, then ch3 back-to-back.
        level[1] = 1'b1;
        level[3] = 1'b1;
        step();
        step();
        check("t2_first_valid", 32'(evt_valid), 32'd1);
        check("t2_first_ch", 32'(evt_ch), 32'd1);
        step();
        check("t2_second_valid", 32'(evt_valid), 32'd1);
        check("t2_second_ch", 32'(evt_ch), 32'd3);
        step();
        check("t2_done", 32'(evt_valid), 32'd0);
        level[1] = 1'b0;
        level[3] = 1'b0;
        step();

        // 3: four pulses on ch2 while the consumer stalls. The counter saturates at 3 and ovf is set.
        evt_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            level[2] = 1'b1;
            step();
            level[2] = 1'b0;
            step();
        end
        check("t3_valid", 32'(evt_valid), 32'd1);
        check("t3_ch", 32'(evt_ch), 32'd2);
        check("t3_ovf_set", 32'(ovf), 32'h4);
        evt_ready = 1'b1;
        cnt2 = 0;
        cnt_other = 0;
        for (int c = 0; c < 8; c++) begin
            if (evt_valid) begin
                if (evt_ch == 2'd2) cnt2++;
                else cnt_other++;
            end
            step();
        end
        check("t3_ch2_transfers", 32'(cnt2), 32'd3);
        check("t3_other_transfers", 32'(cnt_other), 32'd0);
        check("t3_ovf_sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'h0);

        // 4: the offer stays stable while the consumer holds ready low.
        evt_ready = 1'b0;
        level[1]  = 1'b1;
        step();
        step();
        for (int s = 0; s < 5; s++) begin
            check($sformatf("t4_hold_valid_%0d", s), 32'(evt_valid), 32'd1);
            check($sformatf("t4_hold_ch_%0d", s), 32'(evt_ch), 32'd1);
            step();
        end
        evt_ready = 1'b1;
        step();
        check("t4_done", 32'(evt_valid), 32'd0);
        level[1] = 1'b0;
        step();

        // 5: a level already high at reset release and an edge on a disabled channel give no events.
        reset    = 1'b1;
        level[0] = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("t5_high_at_release", 32'(evt_valid), 32'd0);
        ch_en[2] = 1'b0;
        level[2] = 1'b1;
        step();
        level[2] = 1'b0;
        step();
        step();
        step();
        check("t5_disabled_ch", 32'(evt_valid), 32'd0);
        ch_en[2] = 1'b1;

        // 6: reset during an offer with two events pending.
        evt_ready = 1'b0;
        level[1]  = 1'b1;
        level[3]  = 1'b1;
        step();
        step();
        check("t6_offer_before", 32'(evt_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(evt_valid), 32'd0);
        check("t6_async_ch", 32'(evt_ch), 32'd0);
        step();
        reset     = 1'b0;
        evt_ready = 1'b1;
        cnt_other = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (evt_valid) cnt_other++;
        end
        check("t6_no_events_after", 32'(cnt_other), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
